// File: rtl/ehgu_fifo_pkg.sv
// rtl/ehgu_fifo_pkg.sv - pointer type and wrap/level helpers shared by the ehgu FIFO read and write sides
package ehgu_fifo_pkg;

    localparam int unsigned EHGU_AWIDTH = 8;

    typedef logic [EHGU_AWIDTH:0] ptr_t;

    // DEPTH need not be a power of two, so the address wraps explicitly and the phase bit marks each lap.
    function automatic ptr_t ptr_incr(input ptr_t ptr, input int unsigned depth);
        logic [EHGU_AWIDTH-1:0] addr;
        logic                   phase;
        addr  = ptr[EHGU_AWIDTH-1:0];
        phase = ptr[EHGU_AWIDTH];
        if (addr == EHGU_AWIDTH'(depth - 1)) begin
            return {~phase, {EHGU_AWIDTH{1'b0}}};
        end
        return {phase, addr + EHGU_AWIDTH'(1)};
    endfunction

    function automatic ptr_t ptr_level(input ptr_t wptr, input ptr_t rptr, input int unsigned depth);
        int unsigned waddr;
        int unsigned raddr;
        waddr = 32'(wptr[EHGU_AWIDTH-1:0]);
        raddr = 32'(rptr[EHGU_AWIDTH-1:0]);
        if (wptr[EHGU_AWIDTH] == rptr[EHGU_AWIDTH]) begin
            return ptr_t'(waddr - raddr);
        end
        return ptr_t'(depth - raddr + waddr);
    endfunction

endpackage

// File: rtl/ehgu_skid_buf.sv
// rtl/ehgu_skid_buf.sv - two-entry valid/ready output buffer with registered head word
module ehgu_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [1:0]       bufcnt
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             deq;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        deq    = valid_q & dout_ready;
        // Head is the output register; it only changes when empty or on a dequeue, so a stalled word holds.
        if (deq) begin
            if (cnt_q == 2'd2) begin
                head_d = tail_q;
                if (push) begin
                    tail_d = data_in;
                end
            end else if (push) begin
                head_d = data_in;
            end
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                head_d = data_in;
            end else begin
                tail_d = data_in;
            end
        end
        cnt_d   = cnt_q + {1'b0, push} - {1'b0, deq};
        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign dout       = head_q;
    assign dout_valid = valid_q;
    assign bufcnt     = cnt_q;

endmodule

// File: rtl/ehgu_fifo_rd_stream.sv
// rtl/ehgu_fifo_rd_stream.sv - FIFO read side: pointer compare, RAM read issue and valid/ready output stream
module ehgu_fifo_rd_stream
    import ehgu_fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned AWIDTH = EHGU_AWIDTH,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [AWIDTH:0]   wptr,
    output logic [AWIDTH:0]   rptr,
    output logic              renable,
    output logic [AWIDTH-1:0] raddr,
    input  logic [WIDTH-1:0]  rdata,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              empty,
    output logic [AWIDTH:0]   level
);

    ptr_t       rptr_q, rptr_d;
    logic       inflight_q, inflight_d;
    logic [1:0] bufcnt;
    logic [2:0] occ;
    logic       deq;

    always_comb begin
        deq   = dout_valid & dout_ready;
        // Words already committed to the buffer after this clock; a new read may only be issued if one slot stays free.
        occ   = {1'b0, bufcnt} + {2'b00, inflight_q} - {2'b00, deq};
        empty = (wptr == rptr_q);
        level = ptr_level(wptr, rptr_q, DEPTH);

        renable    = en & ~empty & (occ < 3'd2);
        rptr_d     = renable ? ptr_incr(rptr_q, DEPTH) : rptr_q;
        inflight_d = renable;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
        end
    end

    assign rptr  = rptr_q;
    assign raddr = rptr_q[AWIDTH-1:0];

    ehgu_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .data_in    (rdata),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .bufcnt     (bufcnt)
    );

    level_in_range: assert property (@(posedge clk) disable iff (rst) 32'(level) <= DEPTH);

endmodule
